rx_header_sync: RTL and testbench

Receive-side counterpart to the transmit header insertion stage. Takes filtered 12-bit I/Q samples at one sample per symbol and makes a hard sign decision on each. Searches the decided symbol stream for the known frame header, then strips the header and forwards exactly one payload of 2-bit symbols downstream. Sits between the RX matched filter and the bit-level consumer; its output format matches the TX path's 2-bit `{i,q}` input stream.

---
 rtl/rx_header_sync_if.sv | 20 ++
 rtl/rx_header_sync.sv | 98 +++++++++
 tb/tb_rx_header_sync.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_header_sync_if.sv
// Sample-in / symbol-out stream bundle for the RX header synchroniser.
interface rx_header_sync_if;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rx_header_sync.sv
// Hard-slices I/Q samples, hunts for the frame header, then forwards one payload of {i,q} symbols.
// Output register gives 1 symbol/cycle; in_ready drops only while a registered symbol is stalled.
module rx_header_sync #(
  parameter int          HEADER_LEN     = 16,
  parameter logic [31:0] HEADER_PATTERN = 32'hF3A0_5C96,
  parameter int          MAX_ERR        = 0,
  parameter int          PAYLOAD_LEN    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  rx_header_sync_if.slave  bus,
  output logic             locked,
  output logic [15:0]      frame_count
);

  localparam int              W        = 2 * HEADER_LEN;
  localparam logic [W-1:0]    PAT      = HEADER_PATTERN[W-1:0];
  localparam logic [5:0]      HL       = 6'(HEADER_LEN);
  localparam logic [6:0]      MAXE     = 7'(MAX_ERR);
  localparam logic [15:0]     LAST_IDX = 16'(PAYLOAD_LEN - 1);

  localparam logic [0:0] SEARCH  = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] window;
  logic [W-1:0] next_window;
  logic [5:0]   fill;
  logic [15:0]  pcnt;
  logic [6:0]   mism;
  logic         accept;
  logic         sym_i;
  logic         sym_q;
  logic         detect;
  logic         is_last;

  // A symbol still waiting downstream blocks intake in both states.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sym_i        = ~bus.in_data[23];
  assign sym_q        = ~bus.in_data[11];
  assign next_window  = {window[W-3:0], sym_i, sym_q};
  assign is_last      = (pcnt == LAST_IDX);

  always_comb begin
    mism = '0;
    for (int k = 0; k < W; k++) begin
      mism = mism + 7'(next_window[k] ^ PAT[k]);
    end
  end

  assign detect = accept && (state == SEARCH) && ((fill + 6'd1) >= HL) && (mism <= MAXE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= SEARCH;
      window        <= '0;
      fill          <= '0;
      pcnt          <= '0;
      locked        <= 1'b0;
      frame_count   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      locked <= detect;
      case (state)
        SEARCH: begin
          if (detect) begin
            state  <= PAYLOAD;
            window <= '0;
            fill   <= '0;
            pcnt   <= '0;
            if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
          end else if (accept) begin
            window <= next_window;
            if (fill != HL) fill <= fill + 6'd1;
          end
        end
        default: begin
          if (accept) begin
            pcnt <= pcnt + 16'd1;
            if (is_last) state <= SEARCH;
          end
        end
      endcase

      if (accept && (state == PAYLOAD)) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= {sym_i, sym_q};
        bus.out_last  <= is_last;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_header_sync.sv
// Directed bench: driver pushes expected payload symbols, negedge monitor pops and compares.
module tb_rx_header_sync;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk0, lk1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  rx_header_sync_if if0 ();
  rx_header_sync_if if1 ();

  // Second instance tolerates one bit error; it mirrors the first one's input.
  assign if1.in_valid  = if0.in_valid;
  assign if1.in_data   = if0.in_data;
  assign if1.out_ready = 1'b1;

  rx_header_sync #(.MAX_ERR(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .locked(lk0), .frame_count(fc0));
  rx_header_sync #(.MAX_ERR(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .locked(lk1), .frame_count(fc1));

  localparam logic [11:0] P   = 12'h3E8;
  localparam logic [11:0] N   = 12'hC18;
  localparam logic [31:0] HDR = 32'hF3A0_5C96;

  int checks = 0, errors = 0, cyc = 0;
  int lock_cnt = 0, last_cnt = 0, out_cnt = 0, l1 = 0, o1 = 0, first_cyc = 0;
  bit chk_gap = 1'b0, stalled = 1'b0;
  logic [2:0] held;
  logic [3:0] e;
  logic [3:0] sbq[$];   // {first, last, data}

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lk0) lock_cnt++;
    if (lk1) l1++;
    if (if1.out_valid) o1++;
    if (if0.out_valid && !if0.out_ready) begin
      checks++;
      if (if0.in_ready || (stalled && {if0.out_last, if0.out_data} != held)) begin
        errors++;
        $display("FAIL stall_hold: in_ready=%0b dat=%b held=%b", if0.in_ready, {if0.out_last, if0.out_data}, held);
      end
      stalled = 1'b1;
      held    = {if0.out_last, if0.out_data};
    end else begin
      stalled = 1'b0;
    end
    if (if0.out_valid && if0.out_ready) begin
      out_cnt++;
      if (if0.out_last) last_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got last/dat=%b, none expected", {if0.out_last, if0.out_data});
      end else begin
        e = sbq.pop_front();
        if ({if0.out_last, if0.out_data} != e[2:0]) begin
          errors++;
          $display("FAIL payload_sym: got last/dat=%b expected %b", {if0.out_last, if0.out_data}, e[2:0]);
        end
        if (e[3]) first_cyc = cyc;
        if (e[2] && chk_gap) begin
          checks++;
          if (cyc - first_cyc != 63) begin
            errors++;
            $display("FAIL payload_span: got %0d cycles expected 63", cyc - first_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  task automatic send(input logic [1:0] s);
    bit r;
    int n = 0;
    if0.in_valid = 1'b1;
    if0.in_data  = {s[1] ? P : N, s[0] ? P : N};
    do begin
      @(negedge clk);
      r = if0.in_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 200);
    #1;
    if0.in_valid = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never seen");
    end
  endtask

  task automatic idle(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input logic [31:0] h, input bit gaps, input bit exp_lock);
    for (int k = 0; k < 16; k++) begin
      idle(gaps);
      send(h[31-2*k -: 2]);
    end
    chk("lock_timing", 32'(lk0), 32'(exp_lock));
  endtask

  task automatic send_pay(input int n, input bit push, input bit gaps);
    logic [1:0] s;
    for (int k = 0; k < n; k++) begin
      s = (k % 2 == 0) ? 2'b11 : 2'b00;
      if (push) sbq.push_back({k == 0, k == 63, s});
      idle(gaps);
      send(s);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  int b_lock, b_last, b_out, b_l1, b_o1;

  task automatic mark();
    b_lock = lock_cnt; b_last = last_cnt; b_out = out_cnt; b_l1 = l1; b_o1 = o1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_data   = '0;
    if0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_out_data", 32'(if0.out_data), 0);
    chk("rst_out_last", 32'(if0.out_last), 0);
    chk("rst_locked", 32'(lk0), 0);
    chk("rst_frame_count", 32'(fc0), 0);

    // Clean frame at full rate.
    chk_gap = 1'b1;
    mark();
    send_hdr(HDR, 1'b0, 1'b1);
    send_pay(64, 1'b1, 1'b0);
    drain();
    chk("t1_locks", lock_cnt - b_lock, 1);
    chk("t1_outs", out_cnt - b_out, 64);
    chk("t1_lasts", last_cnt - b_last, 1);
    chk("t1_frame_count", 32'(fc0), 1);

    // One flipped header bit: strict instance ignores it, tolerant instance locks.
    do_reset();
    mark();
    send_hdr(HDR ^ 32'h0000_0100, 1'b0, 1'b0);
    send_pay(64, 1'b0, 1'b0);
    drain();
    chk("t2_locks", lock_cnt - b_lock, 0);
    chk("t2_outs", out_cnt - b_out, 0);
    chk("t2_frame_count", 32'(fc0), 0);
    chk("t2_err1_locks", l1 - b_l1, 1);
    chk("t2_err1_outs", o1 - b_o1, 64);
    chk("t2_err1_frame_count", 32'(fc1), 1);

    // Junk lead-in and random in_valid gaps.
    do_reset();
    chk_gap = 1'b0;
    mark();
    for (int k = 0; k < 5; k++) begin
      idle(1'b1);
      send(2'b00);
    end
    send_hdr(HDR, 1'b1, 1'b1);
    send_pay(64, 1'b1, 1'b1);
    drain();
    chk("t3_locks", lock_cnt - b_lock, 1);
    chk("t3_outs", out_cnt - b_out, 64);
    chk("t3_lasts", last_cnt - b_last, 1);

    // Ten-cycle downstream stall mid-payload.
    do_reset();
    mark();
    send_hdr(HDR, 1'b0, 1'b1);
    fork
      send_pay(64, 1'b1, 1'b0);
      begin
        repeat (25) @(posedge clk);
        #1;
        if0.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if0.out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_outs", out_cnt - b_out, 64);
    chk("t4_lasts", last_cnt - b_last, 1);

    // Two frames back to back.
    do_reset();
    chk_gap = 1'b1;
    mark();
    send_hdr(HDR, 1'b0, 1'b1);
    send_pay(64, 1'b1, 1'b0);
    send_hdr(HDR, 1'b0, 1'b1);
    send_pay(64, 1'b1, 1'b0);
    drain();
    chk("t5_frame_count", 32'(fc0), 2);
    chk("t5_outs", out_cnt - b_out, 128);
    chk("t5_lasts", last_cnt - b_last, 2);

    // Reset pulse after payload symbol 30, then a clean frame.
    do_reset();
    mark();
    send_hdr(HDR, 1'b0, 1'b1);
    send_pay(30, 1'b1, 1'b0);
    do_reset();
    chk("t6_out_valid", 32'(if0.out_valid), 0);
    chk("t6_out_data", 32'(if0.out_data), 0);
    chk("t6_out_last", 32'(if0.out_last), 0);
    chk("t6_frame_count_rst", 32'(fc0), 0);
    chk("t6_lasts_abort", last_cnt - b_last, 0);
    send_hdr(HDR, 1'b0, 1'b1);
    send_pay(64, 1'b1, 1'b0);
    drain();
    chk("t6_frame_count", 32'(fc0), 1);
    chk("t6_lasts", last_cnt - b_last, 1);

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
